// File: rtl/spi_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : spi_slave
//  Description : SPI responder. Oversamples the master's sck/mosi/ss in the
//                clk domain, shifts in one FRAME_BITS-bit word per frame and
//                shifts out a word captured from din_i. A completed word is
//                presented on dat_o with a one-clk rco_o strobe.
//
//  Parameters  : FRAME_BITS  - bits per frame (>= 2)
//                SYNC_STAGES - flops in each input synchronizer (>= 2)
//
//  Ports       : clk_i      system clock
//                nrst_i     synchronous active-low reset
//                enable_i   1 = respond to ss_i, 0 = ignore the bus
//                din_i      transmit word, captured at frame start
//                cpol_i     sck idle level
//                cpha_i     0: sample on leading edge, 1: on trailing edge
//                order_i    0: MSB first, 1: LSB first
//                sck_i      serial clock from master (asynchronous)
//                mosi_i     serial data from master (asynchronous)
//                ss_i       active-low select from master (asynchronous)
//                miso_o     serial data to master
//                miso_oe_o  miso drive enable, high only while selected
//                dat_o      last complete received word
//                rco_o      one-clk pulse when dat_o is updated
//                busy_o     frame in progress
//                ferr_o     sticky framing error (only with SPI_SLAVE_ERR_EN)
//
//  Options     : define SPI_SLAVE_ERR_EN to add the ferr_o framing-error
//                output; without it aborted frames are silent.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  nrst_i,
  input  logic                  enable_i,
  input  logic [FRAME_BITS-1:0] din_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  order_i,
  input  logic                  sck_i,
  input  logic                  mosi_i,
  input  logic                  ss_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  output logic [FRAME_BITS-1:0] dat_o,
  output logic                  rco_o,
  output logic                  busy_o
`ifdef SPI_SLAVE_ERR_EN
  ,
  output logic                  ferr_o
`endif
);

  localparam int                  c_CNT_W = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(FRAME_BITS - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sck_dly_q, ss_dly_q;

  state_t                 state_q,   state_d;
  logic [FRAME_BITS-1:0]  tx_q,      tx_d;
  logic [FRAME_BITS-1:0]  rx_q,      rx_d;
  logic [FRAME_BITS-1:0]  dat_q,     dat_d;
  logic [c_CNT_W-1:0]     cnt_q,     cnt_d;
  logic                   rco_q,     rco_d;
  logic                   busy_q,    busy_d;
  logic                   miso_q,    miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   hold_q,    hold_d;
  logic                   cpol_q,    cpol_d;
  logic                   cpha_q,    cpha_d;
  logic                   order_q,   order_d;
`ifdef SPI_SLAVE_ERR_EN
  logic                   ferr_q,    ferr_d;
`endif

  // --------------------------------------------------------------------------
  // Synchronized bus view
  // --------------------------------------------------------------------------
  logic                  w_sck, w_sck_edge, w_mosi;
  logic                  w_ss_filt, w_ss_fall;
  logic                  w_lead, w_trail, w_sample, w_shift;
  logic [FRAME_BITS-1:0] w_rx_shift, w_tx_shift;

  assign w_sck      = sck_sync_q[SYNC_STAGES-1];
  assign w_mosi     = mosi_sync_q[SYNC_STAGES-1];
  assign w_sck_edge = w_sck ^ sck_dly_q;

  // ss only changes once every synchronizer stage agrees, so a pulse shorter
  // than SYNC_STAGES clk never fills the chain and is dropped. The delayed
  // copy doubles as the hold value while the stages disagree.
  assign w_ss_filt = (&ss_sync_q)  ? 1'b1 :
                     (~|ss_sync_q) ? 1'b0 : ss_dly_q;
  assign w_ss_fall = ss_dly_q & ~w_ss_filt;

  // Leading edge leaves the latched idle level, trailing edge returns to it.
  assign w_lead   = w_sck_edge & (w_sck != cpol_q);
  assign w_trail  = w_sck_edge & (w_sck == cpol_q);
  assign w_sample = cpha_q ? w_trail : w_lead;
  assign w_shift  = cpha_q ? w_lead  : w_trail;

  // Receive direction follows the bit order so dat_o is in natural order.
  assign w_rx_shift = order_q ? {w_mosi, rx_q[FRAME_BITS-1:1]}
                              : {rx_q[FRAME_BITS-2:0], w_mosi};
  assign w_tx_shift = order_q ? {1'b0, tx_q[FRAME_BITS-1:1]}
                              : {tx_q[FRAME_BITS-2:0], 1'b0};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    rco_d     = 1'b0;
    busy_d    = busy_q;
    miso_oe_d = miso_oe_q;
    hold_d    = hold_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    order_d   = order_q;
`ifdef SPI_SLAVE_ERR_EN
    ferr_d    = ferr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        busy_d    = 1'b0;
        miso_oe_d = 1'b0;
        if (enable_i && w_ss_fall) begin
          state_d   = ST_ACTIVE;
          tx_d      = din_i;
          cnt_d     = '0;
          cpol_d    = cpol_i;
          cpha_d    = cpha_i;
          order_d   = order_i;
          // With cpha=1 the first leading edge only marks the bit that is
          // already on miso, so that shift is swallowed.
          hold_d    = cpha_i;
          busy_d    = 1'b1;
          miso_oe_d = 1'b1;
`ifdef SPI_SLAVE_ERR_EN
          ferr_d    = 1'b0;
`endif
        end
`ifdef SPI_SLAVE_ERR_EN
        else if (enable_i && w_ss_filt && w_sck_edge) begin
          ferr_d = 1'b1;
        end
`endif
      end

      ST_ACTIVE: begin
        if (w_shift) begin
          if (hold_q) begin
            hold_d = 1'b0;
          end else begin
            tx_d = w_tx_shift;
          end
        end

        if (w_sample) begin
          if (cnt_q == c_LAST) begin
            dat_d  = w_rx_shift;
            rx_d   = w_rx_shift;
            rco_d  = 1'b1;
            cnt_d  = '0;
            tx_d   = din_i;
            // The reloaded word's first bit is already on miso; the next
            // shift edge (trailing for cpha=0, leading for cpha=1) belongs
            // to the frame boundary and must not consume it.
            hold_d = 1'b1;
          end else begin
            rx_d   = w_rx_shift;
            cnt_d  = cnt_q + 1'b1;
          end
        end

        // Evaluated after the sample so a final bit that lands in the same
        // clk as ss rising still completes the word.
        if (w_ss_filt) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          miso_oe_d = 1'b0;
          cnt_d     = '0;
`ifdef SPI_SLAVE_ERR_EN
          if ((cnt_q != '0) && !rco_d) begin
            ferr_d = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    miso_d = (state_d == ST_ACTIVE) ? (order_d ? tx_d[0] : tx_d[FRAME_BITS-1])
                                    : 1'b0;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      // sck starts at the selected idle level to avoid a phantom edge.
      // ss starts low so a frame that was in flight across reset is only
      // accepted after ss has been seen high again.
      sck_sync_q  <= {SYNC_STAGES{cpol_i}};
      sck_dly_q   <= cpol_i;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      ss_dly_q    <= 1'b0;
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      rco_q       <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      hold_q      <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      order_q     <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
      ferr_q      <= 1'b0;
`endif
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      sck_dly_q   <= w_sck;
      ss_dly_q    <= w_ss_filt;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      rco_q       <= rco_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      hold_q      <= hold_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      order_q     <= order_d;
`ifdef SPI_SLAVE_ERR_EN
      ferr_q      <= ferr_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign miso_o    = miso_q;
  assign miso_oe_o = miso_oe_q;
  assign dat_o     = dat_q;
  assign rco_o     = rco_q;
  assign busy_o    = busy_q;
`ifdef SPI_SLAVE_ERR_EN
  assign ferr_o    = ferr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Directed bench for spi_slave. A behavioural SPI master
//                drives sck/mosi/ss; expected words are hand-computed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         nrst, enable, cpol, cpha, order, sck, mosi, ss;
  logic [W-1:0] din;
  logic         miso, miso_oe, rco, busy;
  logic [W-1:0] dat;
`ifdef SPI_SLAVE_ERR_EN
  logic         ferr;
`endif

  always #5 clk = ~clk;

  spi_slave #(.FRAME_BITS(W), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .nrst_i    (nrst),
    .enable_i  (enable),
    .din_i     (din),
    .cpol_i    (cpol),
    .cpha_i    (cpha),
    .order_i   (order),
    .sck_i     (sck),
    .mosi_i    (mosi),
    .ss_i      (ss),
    .miso_o    (miso),
    .miso_oe_o (miso_oe),
    .dat_o     (dat),
    .rco_o     (rco),
    .busy_o    (busy)
`ifdef SPI_SLAVE_ERR_EN
    ,
    .ferr_o    (ferr)
`endif
  );

  // Running totals, sampled on the falling edge.
  int           rco_total = 0, oe_total = 0, busy_total = 0;
  logic [W-1:0] rco_log [64];

  always @(negedge clk) begin
    if (rco) begin
      rco_log[rco_total % 64] = dat;
      rco_total++;
    end
    if (miso_oe) oe_total++;
    if (busy)    busy_total++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Clocks nbits bits of one frame; ss is handled by the caller.
  task automatic master_bits(input logic [W-1:0] word, input int nbits, input int half,
                             input bit din_hook, input logic [W-1:0] din_next,
                             output logic [W-1:0] rx);
    int bi;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bi = order ? i : (W - 1 - i);
      if (!cpha) mosi = word[bi];
      repeat (half) @(negedge clk);
      if (!cpha) rx[bi] = miso;
      sck = ~cpol;
      if (cpha) mosi = word[bi];
      if (din_hook && (i == 1)) din = din_next;
      repeat (half) @(negedge clk);
      if (cpha) rx[bi] = miso;
      sck = cpol;
    end
    repeat (half) @(negedge clk);
  endtask

  task automatic frame(input logic [W-1:0] word, input int half, output logic [W-1:0] rx);
    ss = 1'b0;
    master_bits(word, W, half, 1'b0, '0, rx);
    ss = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic ord);
    cpol = pol; cpha = pha; order = ord; sck = pol;
    repeat (12) @(negedge clk);
  endtask

  typedef struct {
    logic         cpol;
    logic         cpha;
    logic         order;
    int           half;
    logic [W-1:0] mtx;
    logic [W-1:0] din;
    logic [W-1:0] exp_dat;
    logic [W-1:0] exp_mrx;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] mrx, mrx0, mrx1;
    int rb, ob, bb;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 125, 32'h12345678, 32'hADE1B055, 32'h12345678, 32'hADE1B055};
    vecs[1] = '{1'b0, 1'b0, 1'b1,   8, 32'h00000001, 32'h80000000, 32'h00000001, 32'h80000000};
    vecs[2] = '{1'b0, 1'b1, 1'b0,   6, 32'hA5C30F96, 32'h13579BDF, 32'hA5C30F96, 32'h13579BDF};
    vecs[3] = '{1'b1, 1'b0, 1'b1,   5, 32'h80000001, 32'hFEDCBA98, 32'h80000001, 32'hFEDCBA98};
    vecs[4] = '{1'b0, 1'b0, 1'b0,   4, 32'hDEADBEEF, 32'h0000FFFF, 32'hDEADBEEF, 32'h0000FFFF};

    nrst = 1'b0; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; order = 1'b0;
    sck = 1'b0; mosi = 1'b0; ss = 1'b1; din = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset dat",     dat,          32'h0);
    check("reset rco",     32'(rco),     32'h0);
    check("reset miso",    32'(miso),    32'h0);
    check("reset miso_oe", 32'(miso_oe), 32'h0);
    check("reset busy",    32'(busy),    32'h0);
`ifdef SPI_SLAVE_ERR_EN
    check("reset ferr",    32'(ferr),    32'h0);
`endif
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // Single frames in every mode and both bit orders.
    for (int k = 0; k < 5; k++) begin
      din = vecs[k].din;
      set_mode(vecs[k].cpol, vecs[k].cpha, vecs[k].order);
      rb = rco_total; ob = oe_total;
      frame(vecs[k].mtx, vecs[k].half, mrx);
      check($sformatf("v%0d dat", k),        dat,                vecs[k].exp_dat);
      check($sformatf("v%0d rco count", k),  32'(rco_total - rb), 32'd1);
      check($sformatf("v%0d dat at rco", k), rco_log[rb % 64],   vecs[k].exp_dat);
      check($sformatf("v%0d master rx", k),  mrx,                vecs[k].exp_mrx);
      check($sformatf("v%0d oe seen", k),    32'(oe_total > ob), 32'd1);
    end

    // Back-to-back frames with ss held low; din updated inside frame 1.
    set_mode(1'b0, 1'b0, 1'b0);
    din = 32'h11112222;
    rb = rco_total;
    ss = 1'b0;
    master_bits(32'hCAFEBABE, W, 6, 1'b1, 32'h33334444, mrx0);
    master_bits(32'h0F0F0F0F, W, 6, 1'b0, '0, mrx1);
    ss = 1'b1;
    repeat (12) @(negedge clk);
    check("b2b rco count",  32'(rco_total - rb), 32'd2);
    check("b2b word 1",     rco_log[rb % 64],       32'hCAFEBABE);
    check("b2b word 2",     rco_log[(rb + 1) % 64], 32'h0F0F0F0F);
    check("b2b master rx1", mrx0, 32'h11112222);
    check("b2b master rx2", mrx1, 32'h33334444);
`ifdef SPI_SLAVE_ERR_EN
    check("ferr before abort", 32'(ferr), 32'h0);
`endif

    // Abort after 13 bits, then a full frame.
    rb = rco_total;
    ss = 1'b0;
    master_bits(32'h55555555, 13, 6, 1'b0, '0, mrx);
    ss = 1'b1;
    repeat (12) @(negedge clk);
    check("abort rco count", 32'(rco_total - rb), 32'd0);
    check("abort dat kept",  dat, 32'h0F0F0F0F);
    check("abort busy",      32'(busy), 32'h0);
`ifdef SPI_SLAVE_ERR_EN
    check("abort ferr set",  32'(ferr), 32'h1);
`endif
    din = 32'h600DCAFE;
    rb = rco_total;
    frame(32'hFFFFFFFF, 6, mrx);
    check("post-abort dat",       dat, 32'hFFFFFFFF);
    check("post-abort rco count", 32'(rco_total - rb), 32'd1);
    check("post-abort master rx", mrx, 32'h600DCAFE);
`ifdef SPI_SLAVE_ERR_EN
    check("ferr cleared",         32'(ferr), 32'h0);
`endif

    // One-clk glitch on ss must not start a frame.
    bb = busy_total; ob = oe_total;
    ss = 1'b0;
    @(negedge clk);
    ss = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch busy", 32'(busy_total - bb), 32'd0);
    check("glitch oe",   32'(oe_total - ob),   32'd0);

    // Disabled: full frame on the bus is ignored.
    enable = 1'b0;
    rb = rco_total; ob = oe_total; bb = busy_total;
    frame(32'h1234ABCD, 6, mrx);
    check("disabled oe",   32'(oe_total - ob),    32'd0);
    check("disabled busy", 32'(busy_total - bb),  32'd0);
    check("disabled rco",  32'(rco_total - rb),   32'd0);
    check("disabled dat",  dat, 32'hFFFFFFFF);
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in the middle of a frame, then a clean frame.
    set_mode(1'b1, 1'b1, 1'b0);
    din = 32'hAAAA5555;
    rb = rco_total;
    fork
      frame(32'h2468ACE0, 6, mrx);
      begin
        repeat (100) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'h1);
        nrst = 1'b0;
        @(negedge clk);
        check("mid reset dat",     dat,          32'h0);
        check("mid reset busy",    32'(busy),    32'h0);
        check("mid reset miso_oe", 32'(miso_oe), 32'h0);
        check("mid reset miso",    32'(miso),    32'h0);
        check("mid reset rco",     32'(rco),     32'h0);
        nrst = 1'b1;
      end
    join
    check("reset frame rco", 32'(rco_total - rb), 32'd0);
    din = 32'h7E571234;
    rb = rco_total;
    frame(32'h0BADF00D, 6, mrx);
    check("after reset dat",       dat, 32'h0BADF00D);
    check("after reset rco",       32'(rco_total - rb), 32'd1);
    check("after reset master rx", mrx, 32'h7E571234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
